ppe_rr_sched: RTL and testbench

Round-robin grant scheduler for a 512-wide request vector, built around a programmable-priority search whose start point is a registered pointer. It serialises access to one shared downstream resource. Each cycle it picks the first pending requester at or above the pointer, wrapping to index 0. It presents the winner index over a valid/ready handshake, optionally holds the grant for a short burst, then advances the pointer past the winner.

---
 rtl/ppe_rr_sched.sv | 158 +++++++++++++++
 tb/tb_ppe_rr_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ppe_rr_sched.sv
// ppe_rr_sched: round-robin grant scheduler for a W-wide level request vector.
// The search starts at a registered pointer, wraps to index 0, and the winner
// is held over a valid/ready handshake for up to BURST_MAX beats. After the
// final beat the pointer moves one past the winner.
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   req[W-1:0]     in   level requests, one bit per requester
//   gnt_valid      out  grant presented (registered)
//   gnt_idx[IW-1:0] out index of granted requester (registered)
//   gnt_last       out  current beat is final; combinational from live req
//   gnt_ready      in   downstream accepts the current beat
//
// Optional feature, enabled by defining PPE_SCHED_STATS_EN:
//   stat_gnt_cnt[31:0]  out  count of final accepts
//   stat_idle_cnt[31:0] out  count of IDLE cycles with no registered request
module ppe_rr_sched #(
    parameter int unsigned W         = 512,
    parameter int unsigned IW        = 9,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  req,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_last,
    input  logic          gnt_ready
`ifdef PPE_SCHED_STATS_EN
    ,
    output logic [31:0]   stat_gnt_cnt,
    output logic [31:0]   stat_idle_cnt
`endif
);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_GRANT   = 1'b1;
    localparam logic [3:0] BEAT_LAST = 4'(BURST_MAX - 1);

    logic [0:0]    r_state;
    logic [W-1:0]  r_req_q;
    logic [IW-1:0] r_ptr;
    logic [3:0]    r_beat_cnt;
    logic [IW-1:0] r_gnt_idx;
    logic          r_gnt_valid;

    logic [0:0]    w_state_nxt;
    logic [IW-1:0] w_ptr_nxt;
    logic [3:0]    w_beat_nxt;
    logic [IW-1:0] w_idx_nxt;
    logic          w_valid_nxt;
    logic          w_gnt_done;

    logic [W-1:0]  w_hi_mask;
    logic [W-1:0]  w_req_hi;
    logic          w_hi_any;
    logic [IW-1:0] w_hi_idx;
    logic [IW-1:0] w_lo_idx;
    logic [IW-1:0] w_win_idx;

    // Requests at or above the pointer take priority; otherwise wrap to the lowest overall.
    assign w_hi_mask = {W{1'b1}} << r_ptr;
    assign w_req_hi  = r_req_q & w_hi_mask;
    assign w_hi_any  = |w_req_hi;

    // Two priority encoders (lowest set bit wins); the masked one is preferred.
    always_comb begin
        w_hi_idx = '0;
        w_lo_idx = '0;
        for (int i = int'(W) - 1; i >= 0; i--) begin
            if (w_req_hi[i]) w_hi_idx = IW'(i);
            if (r_req_q[i])  w_lo_idx = IW'(i);
        end
    end

    assign w_win_idx = w_hi_any ? w_hi_idx : w_lo_idx;

    // Live req lets a requester that drops its request end the burst early.
    assign gnt_last  = r_gnt_valid & ((r_beat_cnt == BEAT_LAST) | ~req[r_gnt_idx]);
    assign gnt_valid = r_gnt_valid;
    assign gnt_idx   = r_gnt_idx;

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_beat_nxt  = r_beat_cnt;
        w_idx_nxt   = r_gnt_idx;
        w_valid_nxt = r_gnt_valid;
        w_gnt_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|r_req_q) begin
                    w_idx_nxt   = w_win_idx;
                    w_beat_nxt  = 4'd0;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (gnt_ready) begin
                    if (gnt_last) begin
                        // IW-bit add wraps W-1 back to 0.
                        w_ptr_nxt   = r_gnt_idx + IW'(1);
                        w_valid_nxt = 1'b0;
                        w_state_nxt = S_IDLE;
                        w_gnt_done  = 1'b1;
                    end else begin
                        w_beat_nxt  = r_beat_cnt + 4'd1;
                    end
                end
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_req_q     <= '0;
            r_ptr       <= '0;
            r_beat_cnt  <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_q     <= req;
            r_ptr       <= w_ptr_nxt;
            r_beat_cnt  <= w_beat_nxt;
            r_gnt_idx   <= w_idx_nxt;
            r_gnt_valid <= w_valid_nxt;
        end
    end

`ifdef PPE_SCHED_STATS_EN
    logic [31:0] r_stat_gnt;
    logic [31:0] r_stat_idle;

    // Free-running statistics counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_gnt  <= '0;
            r_stat_idle <= '0;
        end else begin
            if (w_gnt_done) r_stat_gnt <= r_stat_gnt + 32'd1;
            if ((r_state == S_IDLE) && !(|r_req_q)) r_stat_idle <= r_stat_idle + 32'd1;
        end
    end

    assign stat_gnt_cnt  = r_stat_gnt;
    assign stat_idle_cnt = r_stat_idle;
`else
    logic w_unused;
    assign w_unused = w_gnt_done;
`endif

endmodule

// File: tb/tb_ppe_rr_sched.sv
// Self-checking bench for ppe_rr_sched: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a reference model.
module tb_ppe_rr_sched;

    localparam int W  = 512;
    localparam int IW = 9;
    localparam int BM = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [W-1:0]  req = '0;
    logic          gnt_ready = 1'b0;
    logic          gnt_valid;
    logic [IW-1:0] gnt_idx;
    logic          gnt_last;
`ifdef PPE_SCHED_STATS_EN
    logic [31:0]   stat_gnt_cnt;
    logic [31:0]   stat_idle_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [W-1:0] m_reqq;
    int           m_ptr;
    bit           m_busy;
    int           m_idx;
    int           m_beats;
    logic [31:0]  m_gnt;
    logic [31:0]  m_idle;

    ppe_rr_sched #(.W(W), .IW(IW), .BURST_MAX(BM)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .gnt_valid(gnt_valid),
        .gnt_idx(gnt_idx),
        .gnt_last(gnt_last),
        .gnt_ready(gnt_ready)
`ifdef PPE_SCHED_STATS_EN
        ,
        .stat_gnt_cnt(stat_gnt_cnt),
        .stat_idle_cnt(stat_idle_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // First requester found walking upward from p, modulo W.
    function automatic int ref_pick(input logic [W-1:0] v, input int p);
        for (int k = 0; k < W; k++) begin
            int j;
            j = (p + k) % W;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic bit ref_last();
        return m_busy && ((m_beats == BM - 1) || !req[m_idx]);
    endfunction

    task automatic model_reset();
        m_reqq = '0; m_ptr = 0; m_busy = 0; m_idx = 0; m_beats = 0;
        m_gnt = '0; m_idle = '0;
    endtask

    // Advance the model by one rising edge, using inputs stable at that edge.
    task automatic model_step();
        bit lst;
        lst = ref_last();
        if (m_busy) begin
            if (gnt_ready) begin
                if (lst) begin
                    m_ptr  = (m_idx + 1) % W;
                    m_busy = 0;
                    m_gnt  = m_gnt + 32'd1;
                end else begin
                    m_beats++;
                end
            end
        end else if (m_reqq != '0) begin
            m_idx   = ref_pick(m_reqq, m_ptr);
            m_beats = 0;
            m_busy  = 1;
        end else begin
            m_idle = m_idle + 32'd1;
        end
        m_reqq = req;
    endtask

    task automatic model_cmp();
        chk("valid", longint'(gnt_valid), longint'(m_busy));
        chk("idx", longint'(gnt_idx), longint'(m_idx));
        chk("last", longint'(gnt_last), longint'(ref_last()));
`ifdef PPE_SCHED_STATS_EN
        chk("stat_gnt", longint'(stat_gnt_cnt), longint'(m_gnt));
        chk("stat_idle", longint'(stat_idle_cnt), longint'(m_idle));
`endif
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        model_cmp();
    endtask

    // Asynchronous reset pulse; outputs must clear before any clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_valid", longint'(gnt_valid), 0);
        chk("rst_idx", longint'(gnt_idx), 0);
        chk("rst_last", longint'(gnt_last), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        int rbit;   // single request bit, -1 for none
        bit ready;
        bit ev;
        int eidx;
        bit el;
    } vec_t;

    vec_t vec[11];

    initial begin
        int q_idx[$];
        int exp_rr[5];
        bit prev_v;
        int n;

        #3;
        do_reset();

        // Burst on requester 5 then early release on the second beat.
        vec[0]  = '{5,  1'b1, 1'b0, 0, 1'b0};
        vec[1]  = '{5,  1'b1, 1'b1, 5, 1'b0};
        vec[2]  = '{5,  1'b1, 1'b1, 5, 1'b0};
        vec[3]  = '{5,  1'b1, 1'b1, 5, 1'b0};
        vec[4]  = '{5,  1'b1, 1'b1, 5, 1'b1};
        vec[5]  = '{5,  1'b1, 1'b0, 5, 1'b0};
        vec[6]  = '{5,  1'b1, 1'b1, 5, 1'b0};
        vec[7]  = '{5,  1'b1, 1'b1, 5, 1'b0};
        vec[8]  = '{-1, 1'b0, 1'b1, 5, 1'b1};
        vec[9]  = '{-1, 1'b1, 1'b0, 5, 1'b0};
        vec[10] = '{-1, 1'b1, 1'b0, 5, 1'b0};
        for (int v = 0; v < 11; v++) begin
            req = '0;
            if (vec[v].rbit >= 0) req[vec[v].rbit] = 1'b1;
            gnt_ready = vec[v].ready;
            step();
            chk($sformatf("vec%0d_valid", v), longint'(gnt_valid), longint'(vec[v].ev));
            chk($sformatf("vec%0d_idx", v), longint'(gnt_idx), longint'(vec[v].eidx));
            chk($sformatf("vec%0d_last", v), longint'(gnt_last), longint'(vec[v].el));
        end

        // Reset mid-grant with everything requesting; first grant is index 0 two edges later.
        req = '1; gnt_ready = 1'b1;
        do_reset();
        step(); step(); step();
        chk("pre_rst_in_grant", longint'(gnt_valid), 1);
        do_reset();
        step();
        chk("post_rst_e1_valid", longint'(gnt_valid), 0);
        step();
        chk("post_rst_e2_valid", longint'(gnt_valid), 1);
        chk("post_rst_e2_idx", longint'(gnt_idx), 0);

        // Round robin with wrap through 511.
        req = '0; gnt_ready = 1'b0;
        do_reset();
        req[3] = 1'b1; req[10] = 1'b1; req[511] = 1'b1; gnt_ready = 1'b1;
        exp_rr = '{3, 10, 511, 3, 10};
        prev_v = 1'b0;
        n = 0;
        while (q_idx.size() < 5 && n < 200) begin
            step();
            if (gnt_valid && !prev_v) q_idx.push_back(int'(gnt_idx));
            prev_v = gnt_valid;
            n++;
        end
        chk("rr_count", longint'(q_idx.size()), 5);
        for (int i = 0; i < q_idx.size(); i++)
            chk($sformatf("rr_order%0d", i), longint'(q_idx[i]), longint'(exp_rr[i]));

        // Backpressure on requester 200 while other bits toggle.
        req = '0; gnt_ready = 1'b0;
        do_reset();
        req[200] = 1'b1;
        n = 0;
        while (!gnt_valid && n < 10) begin step(); n++; end
        chk("bp_granted", longint'(gnt_valid), 1);
        for (int c = 0; c < 6; c++) begin
            for (int b = 0; b < W / 32; b++) req[b*32 +: 32] = $urandom;
            req[200] = 1'b1;
            step();
            chk("bp_valid", longint'(gnt_valid), 1);
            chk("bp_idx", longint'(gnt_idx), 200);
        end
        gnt_ready = 1'b1;
        n = 0;
        while (gnt_valid && n < 20) begin step(); n++; end
        chk("bp_released", longint'(gnt_valid), 0);

        // Empty cycles after reset (idle statistic builds while req_q is zero).
        req = '0; gnt_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 10; c++) step();
`ifdef PPE_SCHED_STATS_EN
        chk("stat_idle10", longint'(stat_idle_cnt), 10);
        chk("stat_gnt0", longint'(stat_gnt_cnt), 0);
`endif

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            int mode;
            mode = int'($urandom_range(0, 9));
            if (mode < 3) begin
                req = '0;
                for (int k = 0; k < int'($urandom_range(0, 3)); k++)
                    req[$urandom_range(0, W - 1)] = 1'b1;
            end else if (mode == 3) begin
                for (int b = 0; b < W / 32; b++) req[b*32 +: 32] = $urandom;
            end else if (mode == 4) begin
                req = '0;
            end
            gnt_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 999) == 0) do_reset();
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
